// File: rtl/time_entry_loader.sv
// time_entry_loader: keypad strobe edge detect, BCD MM:SS entry shift register and start/stop control.
// Optional `define TIME_NORMALIZE_EN folds seconds >= 60 into minutes on an accepted START.
module time_entry_loader #(
  parameter int         MAX_DIGITS = 4,
  parameter logic [3:0] KEY_START  = 4'hA,
  parameter logic [3:0] KEY_STOP   = 4'hB
) (
  input  logic       clk,
  input  logic       clear,
  input  logic [3:0] key_code,
  input  logic       key_strobe,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic [2:0] digit_count,
  output logic       entry_full,
  output logic       time_valid,
  output logic       start_pulse,
  output logic       cancel_pulse,
  output logic       reject
);
  typedef enum logic [1:0] {IDLE, ENTRY, RUN} state_t;
  state_t state_q, state_d;
  logic [3:0] min_tens_q, min_tens_d, min_ones_q, min_ones_d;
  logic [3:0] sec_tens_q, sec_tens_d, sec_ones_q, sec_ones_d;
  logic [2:0] count_q, count_d;
  logic strobe_q, start_q, start_d, cancel_q, cancel_d, reject_q, reject_d;
  logic ev, full, zero;
  assign ev   = key_strobe & ~strobe_q;
  assign full = count_q == 3'(MAX_DIGITS);
  assign zero = {min_tens_q, min_ones_q, sec_tens_q, sec_ones_q} == 16'h0;
  always_comb begin
    state_d    = state_q;
    min_tens_d = min_tens_q;
    min_ones_d = min_ones_q;
    sec_tens_d = sec_tens_q;
    sec_ones_d = sec_ones_q;
    count_d    = count_q;
    start_d    = 1'b0;
    cancel_d   = 1'b0;
    reject_d   = 1'b0;
    if (ev) begin
      if (key_code == KEY_STOP) begin
        cancel_d   = 1'b1;
        state_d    = IDLE;
        min_tens_d = 4'd0;
        min_ones_d = 4'd0;
        sec_tens_d = 4'd0;
        sec_ones_d = 4'd0;
        count_d    = 3'd0;
      end else if (key_code == KEY_START) begin
        if (state_q == IDLE || (state_q == ENTRY && zero)) begin
          reject_d = 1'b1;
        end else if (state_q == ENTRY) begin
          start_d = 1'b1;
          state_d = RUN;
`ifdef TIME_NORMALIZE_EN
          if (sec_tens_q >= 4'd6) begin
            if (min_tens_q == 4'd9 && min_ones_q == 4'd9) begin
              sec_tens_d = 4'd5;
              sec_ones_d = 4'd9;
            end else begin
              sec_tens_d = sec_tens_q - 4'd6;
              min_ones_d = (min_ones_q == 4'd9) ? 4'd0 : min_ones_q + 4'd1;
              min_tens_d = (min_ones_q == 4'd9) ? min_tens_q + 4'd1 : min_tens_q;
            end
          end
`endif
        end
      end else if (key_code <= 4'd9 && state_q != RUN && !full) begin
        min_tens_d = min_ones_q;
        min_ones_d = sec_tens_q;
        sec_tens_d = sec_ones_q;
        sec_ones_d = key_code;
        count_d    = count_q + 3'd1;
        state_d    = ENTRY;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (clear) begin
      state_q    <= IDLE;
      min_tens_q <= 4'd0;
      min_ones_q <= 4'd0;
      sec_tens_q <= 4'd0;
      sec_ones_q <= 4'd0;
      count_q    <= 3'd0;
      strobe_q   <= 1'b1;
      start_q    <= 1'b0;
      cancel_q   <= 1'b0;
      reject_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      min_tens_q <= min_tens_d;
      min_ones_q <= min_ones_d;
      sec_tens_q <= sec_tens_d;
      sec_ones_q <= sec_ones_d;
      count_q    <= count_d;
      strobe_q   <= key_strobe;
      start_q    <= start_d;
      cancel_q   <= cancel_d;
      reject_q   <= reject_d;
    end
  end
  assign min_tens     = min_tens_q;
  assign min_ones     = min_ones_q;
  assign sec_tens     = sec_tens_q;
  assign sec_ones     = sec_ones_q;
  assign digit_count  = count_q;
  assign entry_full   = full;
  assign time_valid   = state_q == RUN;
  assign start_pulse  = start_q;
  assign cancel_pulse = cancel_q;
  assign reject       = reject_q;
endmodule

// File: doc/time_entry_loader.md
Name: time_entry_loader

Overview:
Consumer end of the keypad encoder interface in the microwave controller. Takes the encoder's 4-bit key code and its level strobe, and detects each key press on the strobe's rising edge. Digit keys shift into a four-digit BCD MM:SS time register; start and stop keys control it. Feeds the countdown timer and the display multiplexer with a locked, validated cook time.

Parameters:
MAX_DIGITS, 4, number of digit entries accepted (1..4); upper digits beyond MAX_DIGITS stay 0
KEY_START, 4'hA, encoder code of the START key
KEY_STOP, 4'hB, encoder code of the STOP/CANCEL key

Ports:
clk  input  1  system clock, all logic on rising edge
clear  input  1  synchronous reset, active-high
key_code  input  4  encoder output; 0-9 digits, KEY_START, KEY_STOP, other codes ignored
key_strobe  input  1  encoder valid level, high while a key is held
min_tens  output  4  BCD minutes tens
min_ones  output  4  BCD minutes ones
sec_tens  output  4  BCD seconds tens
sec_ones  output  4  BCD seconds ones
digit_count  output  3  digits entered so far, 0..MAX_DIGITS
entry_full  output  1  high when digit_count == MAX_DIGITS
time_valid  output  1  high while in RUN (time locked for timer)
start_pulse  output  1  one-cycle pulse on accepted START
cancel_pulse  output  1  one-cycle pulse on any processed STOP
reject  output  1  one-cycle pulse on START with zero time

Behaviour:
- Reset (clear=1 at clk edge): all digits 0, digit_count 0, all flags/pulses 0, state IDLE, strobe history register = 1.
- Strobe history set to 1 on reset, so a key held through reset release produces no event.
- Event rule: event in cycle N when key_strobe=1 and its registered value=0.
- key_code is sampled in cycle N. Holding the strobe high yields exactly one event.
- Latency: effect of an event is visible on the outputs in cycle N+1. Pulses are high for cycle N+1 only.
- States: IDLE (count 0), ENTRY (count 1..MAX_DIGITS), RUN (locked).
- Digit event, IDLE/ENTRY, count < MAX_DIGITS: shift left. min_tens<=min_ones<=sec_tens<=sec_ones<=key_code; count+1; IDLE->ENTRY.
- Digit event when count == MAX_DIGITS: ignored, registers unchanged, entry_full stays 1.
- Digit event in RUN: ignored.
- START in IDLE: reject pulse, stay IDLE.
- START in ENTRY with all four digits 0: reject pulse, stay ENTRY, digits kept.
- START in ENTRY with nonzero time: start_pulse, go to RUN; time_valid=1 from cycle N+1.
- START in RUN: ignored.
- STOP in any state: cancel_pulse; digits and count cleared; time_valid=0; go to IDLE.
- Codes 0xC-0xF (and A/B if remapped, any non-digit non-control code): ignored, no pulse.
- clear asserted mid-entry or in RUN: immediate return to reset values on that edge; clear has priority over any event in the same cycle.
- Only one event per cycle by construction; no simultaneous-event cases beyond clear vs event.

Optional Feature:
TIME_NORMALIZE_EN
- Defined: on accepted START, if seconds (10*sec_tens+sec_ones) >= 60, subtract 60 and add 1 minute, with BCD carry into min_tens.
- Defined, minutes already 99: clamp seconds to 59, minutes stay 99.
- Normalized value is visible in cycle N+1 together with time_valid.
- Not defined: digits are locked exactly as entered (e.g. 00:90 stays 00:90).

Test Plan:
- Reset with key_strobe held high and key_code=5, then release clear -> no digit loaded, digit_count=0, digits 0000.
- Press 1,2,3,0 (strobe pulses of 3 cycles each) -> digits 12:30, digit_count=4, entry_full=1; a fifth press '7' -> still 12:30.
- Press 0 then START -> reject pulses 1 cycle, state stays ENTRY, time_valid=0; START in IDLE -> reject pulse.
- Enter 0,0,9,0 then START -> start_pulse 1 cycle, time_valid=1. With TIME_NORMALIZE_EN: 01:30. Without: 00:90. With macro, 99:75 -> 99:59.
- In RUN press 4 and START -> no change; press STOP -> cancel_pulse, digits 0000, time_valid=0, digit_count=0.
- Enter 4,5, then assert clear for one cycle coincident with a '6' strobe edge -> all outputs reset, '6' not loaded.
